// File: rtl/pair_triple_event_counter_pkg.sv
// Shared constants and types for the pair/triple event counter and its pulse stretcher.
package pair_triple_pkg;

  localparam int CNT_W_DEF       = 8;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int STRETCH_CYC_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } stretch_state_t;

  // Width of a down-counter that must hold n-1; never narrower than one bit.
  function automatic int scnt_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pair_triple_event_counter_pulse_stretcher.sv
// Stretches a one-cycle strobe into a registered level held for STRETCH_CYC cycles;
// a strobe arriving while already holding restarts the hold window.
module pulse_stretcher
  import pair_triple_pkg::*;
#(
  parameter int STRETCH_CYC = STRETCH_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pulse_i,
  output logic stretch_o
);

  localparam int                SCNT_W = scnt_width(STRETCH_CYC);
  localparam logic [SCNT_W-1:0] RELOAD = SCNT_W'(STRETCH_CYC - 1);

  stretch_state_t    state_q;
  logic [SCNT_W-1:0] scnt_q;
  logic              stretch_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      scnt_q    <= '0;
      stretch_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pulse_i) begin
            state_q   <= HOLD;
            scnt_q    <= RELOAD;
            stretch_q <= 1'b1;
          end
        end
        HOLD: begin
          // Retrigger wins over expiry so back-to-back events keep the LED lit.
          if (pulse_i) begin
            scnt_q <= RELOAD;
          end else if (scnt_q == '0) begin
            state_q   <= IDLE;
            stretch_q <= 1'b0;
          end else begin
            scnt_q <= scnt_q - SCNT_W'(1);
          end
        end
        default: begin
          state_q   <= IDLE;
          stretch_q <= 1'b0;
        end
      endcase
    end
  end

  assign stretch_o = stretch_q;

endmodule

// File: rtl/pair_triple_event_counter.sv
// Synchronizes the detector output, strobes on its rising edge and counts events.
// Build with PAIR_TRIPLE_CNT_SAT_EN defined to saturate the count instead of wrapping.
module pair_triple_event_counter
  import pair_triple_pkg::*;
#(
  parameter int CNT_W       = CNT_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int STRETCH_CYC = STRETCH_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             det_in,
  input  logic             en,
  input  logic             clr,
  output logic [CNT_W-1:0] count,
  output logic             pulse,
  output logic             stretch_out,
  output logic             ovf
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_out;
  logic                   rise;

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pulse_q;

  // Plain flop chain; det_in is asynchronous so nothing may look at it before the last stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], det_in};
      hist_q <= sync_out;
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign rise     = sync_out & ~hist_q;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (rise && en) begin
      if (count_q == CNT_MAX) begin
        ovf_d = 1'b1;
`ifdef PAIR_TRIPLE_CNT_SAT_EN
        count_d = CNT_MAX;
`else
        count_d = '0;
`endif
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      pulse_q <= rise;
    end
  end

  pulse_stretcher #(
    .STRETCH_CYC(STRETCH_CYC)
  ) u_stretch (
    .clk      (clk),
    .rst_n    (rst_n),
    .pulse_i  (pulse_q),
    .stretch_o(stretch_out)
  );

  assign count = count_q;
  assign ovf   = ovf_q;
  assign pulse = pulse_q;

endmodule
